// File: rtl/store_popcount_unit.sv
// Snoops core word stores inside an address window and emits {index, popcount} per captured word.
// Latency: store in cycle t -> res_valid from t+10 (1 queue + 1 IDLE pop + 32/BITS_PER_CYCLE count beats).
// Backpressure: result holds until res_ready; captures queue in the FIFO and drop with sticky overflow when it is full.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module store_popcount_unit #(
    parameter logic [31:0] WIN_BASE       = 32'h0000_0000,
    parameter int          WIN_WORDS      = 20,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_index,
    output logic [5:0]  res_count,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] done_count
);
    localparam int BEATS = 32 / BITS_PER_CYCLE;
    localparam int BW    = $clog2(BEATS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [32:0] WIN_LO = {1'b0, WIN_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * WIN_WORDS);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t         state;
    state_t         state_next;
    logic           capture;
    logic [4:0]     cap_index;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [36:0]    fifo_head;
    logic [31:0]    shift;
    logic [5:0]     acc;
    logic [5:0]     acc_next;
    logic [BW-1:0]  beat;
    logic [4:0]     cur_index;
    logic           last_beat;

    function automatic logic [5:0] pop_bits(input logic [BITS_PER_CYCLE-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) n = n + 6'(v[i]);
        return n;
    endfunction

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign capture   = MemWrite && (DataAdr[1:0] == 2'b00) &&
                       ({1'b0, DataAdr} >= WIN_LO) && ({1'b0, DataAdr} < WIN_HI);
    assign cap_index = 5'((DataAdr - WIN_BASE) >> 2);

    sync_fifo #(.WIDTH(37), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (capture),
        .push_dat ({cap_index, WriteData}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign acc_next  = acc + pop_bits(shift[BITS_PER_CYCLE-1:0]);
    assign last_beat = (beat == LAST_BEAT);
    assign busy      = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty)  state_next = COUNT;
            COUNT:   if (last_beat)    state_next = HOLD;
            HOLD:    if (res_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        res_valid = (state == HOLD);
        fifo_pop  = (state == IDLE) && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift      <= '0;
            acc        <= '0;
            beat       <= '0;
            cur_index  <= '0;
            res_index  <= '0;
            res_count  <= '0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        shift     <= fifo_head[31:0];
                        cur_index <= fifo_head[36:32];
                        acc       <= '0;
                        beat      <= '0;
                    end
                end
                COUNT: begin
                    acc   <= acc_next;
                    shift <= shift >> BITS_PER_CYCLE;
                    beat  <= beat + 1'b1;
                    if (last_beat) begin
                        res_count <= acc_next;
                        res_index <= cur_index;
                    end
                end
                HOLD: begin
                    if (res_ready) done_count <= done_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                 overflow <= 1'b0;
        else if (capture && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
endmodule
